vga_frame_monitor: RTL and testbench

//  Sink end of the solo_squash VGA interface: samples red/green/blue/hsync/vsync as

---
 rtl/vga_frame_monitor_pkg.sv | 39 +++
 rtl/vga_frame_monitor_if.sv | 11 +
 rtl/vga_edge_sync.sv | 28 ++
 rtl/vga_frame_monitor.sv | 199 +++++++++++++++++++
 tb/tb_vga_frame_monitor.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_frame_monitor_pkg.sv
// Shared definitions for the VGA frame monitor: FSM encoding, 640x480@60 timing
// defaults and the CRC-16-CCITT constants/step function.
package vga_frame_monitor_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_SYNCING = 2'd1,
        ST_LOCKED  = 2'd2
    } mon_state_e;

    localparam int DEF_H_TOTAL     = 800;
    localparam int DEF_V_TOTAL     = 525;
    localparam int DEF_H_VIS_START = 144;
    localparam int DEF_H_VIS       = 640;
    localparam int DEF_V_VIS_START = 35;
    localparam int DEF_V_VIS       = 480;
    localparam int DEF_CNT_W       = 11;

    localparam int LIT_W = 19;
    localparam int CRC_W = 16;

    localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
    localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;

    // Three message bits per pixel clock, MSB-first (r, then g, then b).
    function automatic logic [CRC_W-1:0] crc16_step3(input logic [CRC_W-1:0] crc_in,
                                                     input logic [2:0]       bits);
        logic [CRC_W-1:0] c;
        c = crc_in;
        for (int i = 2; i >= 0; i--) begin
            if (c[CRC_W-1] ^ bits[i])
                c = {c[CRC_W-2:0], 1'b0} ^ CRC_POLY;
            else
                c = {c[CRC_W-2:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/vga_frame_monitor_if.sv
// VGA pin bundle as driven by the game (master) and observed by the monitor (slave).
interface vga_frame_monitor_if;
    logic red;
    logic green;
    logic blue;
    logic hsync;
    logic vsync;

    modport master (output red, green, blue, hsync, vsync);
    modport slave  (input  red, green, blue, hsync, vsync);
endinterface

// File: rtl/vga_edge_sync.sv
// Two-flop synchroniser for one sync line, normalised to active-high, with a
// one-cycle pulse on the leading (inactive->active) edge.
module vga_edge_sync #(
    parameter logic SYNC_POL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sync_in,
    output logic lead
);
    logic [1:0] sync_ff;
    logic       active;
    logic       active_q;

    // Flops reset to the inactive level so release never fakes an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_ff  <= {2{~SYNC_POL}};
            active_q <= 1'b0;
        end else begin
            sync_ff  <= {sync_ff[0], sync_in};
            active_q <= active;
        end
    end

    assign active = (sync_ff[1] == SYNC_POL);
    assign lead   = active & ~active_q;
endmodule

// File: rtl/vga_frame_monitor.sv
// VGA sink-side timing monitor: recovers line/frame timing, checks it against the
// configured mode, counts lit visible pixels. Define VGA_MON_CRC_EN for frame CRC.
module vga_frame_monitor
    import vga_frame_monitor_pkg::*;
#(
    parameter int   H_TOTAL     = DEF_H_TOTAL,
    parameter int   V_TOTAL     = DEF_V_TOTAL,
    parameter int   H_VIS_START = DEF_H_VIS_START,
    parameter int   H_VIS       = DEF_H_VIS,
    parameter int   V_VIS_START = DEF_V_VIS_START,
    parameter int   V_VIS       = DEF_V_VIS,
    parameter logic SYNC_POL    = 1'b0,
    parameter int   CNT_W       = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    vga_frame_monitor_if.slave   vga,
    output logic                 locked,
    output logic                 sync_err,
    output logic                 frame_done,
    output logic [CNT_W-1:0]     line_len,
    output logic [CNT_W-1:0]     frame_lines,
    output logic [LIT_W-1:0]     lit_count,
    output logic [CRC_W-1:0]     frame_crc
);
    localparam logic [CNT_W-1:0] H_TOT_C  = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0] V_TOT_C  = CNT_W'(V_TOTAL);
    localparam logic [CNT_W-1:0] H_MISS_C = CNT_W'(H_TOTAL + H_TOTAL / 2);
    localparam logic [CNT_W-1:0] H_VS_C   = CNT_W'(H_VIS_START);
    localparam logic [CNT_W-1:0] H_VE_C   = CNT_W'(H_VIS_START + H_VIS);
    localparam logic [CNT_W-1:0] V_VS_C   = CNT_W'(V_VIS_START);
    localparam logic [CNT_W-1:0] V_VE_C   = CNT_W'(V_VIS_START + V_VIS);

    logic [1:0]       sync_lead;
    logic             h_lead;
    logic             v_lead;
    logic [1:0][2:0]  rgb_ff;
    logic [2:0]       rgb_s;

    logic [CNT_W-1:0] h_ctr;
    logic [CNT_W-1:0] v_ctr;
    logic [CNT_W-1:0] h_len_cur;
    logic [CNT_W-1:0] v_lines_cur;

    mon_state_e       state;
    mon_state_e       state_nxt;
    logic             line_ok;
    logic             len_bad;
    logic             lines_bad;
    logic             h_miss;
    logic             err;
    logic             vis;
    logic             report;
    logic [LIT_W-1:0] lit_acc;

    // ---------------------------------------------------------------- input sync
    vga_edge_sync #(.SYNC_POL(SYNC_POL)) u_sync [1:0] (
        .clk     (clk),
        .reset_n (reset_n),
        .sync_in ({vga.vsync, vga.hsync}),
        .lead    (sync_lead)
    );

    assign h_lead = sync_lead[0];
    assign v_lead = sync_lead[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rgb_ff <= '0;
        else
            rgb_ff <= {rgb_ff[0], {vga.red, vga.green, vga.blue}};
    end

    assign rgb_s = rgb_ff[1];

    // ---------------------------------------------------------------- counters
    // Measured values include the edge cycle itself, so a coincident h+v edge
    // counts the closing line into the frame before v_ctr restarts.
    assign h_len_cur   = (h_ctr == '1) ? h_ctr : h_ctr + 1'b1;
    assign v_lines_cur = (h_lead && v_ctr != '1) ? v_ctr + 1'b1 : v_ctr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_ctr       <= '0;
            v_ctr       <= '0;
            line_len    <= '0;
            frame_lines <= '0;
        end else begin
            if (h_lead) begin
                h_ctr    <= '0;
                line_len <= h_len_cur;
            end else if (h_ctr != '1) begin
                h_ctr <= h_ctr + 1'b1;
            end

            if (v_lead) begin
                v_ctr       <= '0;
                frame_lines <= v_lines_cur;
            end else if (h_lead && v_ctr != '1) begin
                v_ctr <= v_ctr + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- timing check
    assign len_bad   = h_lead && (h_len_cur != H_TOT_C);
    assign lines_bad = v_lead && (v_lines_cur != V_TOT_C);
    assign h_miss    = !h_lead && (h_ctr == H_MISS_C);

    // A frame qualifies only if every line since its opening vsync was clean.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            line_ok <= 1'b0;
        else if (v_lead)
            line_ok <= 1'b1;
        else if (len_bad || h_miss)
            line_ok <= 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_SEARCH;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err       = 1'b0;
        unique case (state)
            ST_SEARCH: begin
                if (v_lead)
                    state_nxt = ST_SYNCING;
            end
            ST_SYNCING: begin
                if (v_lead && line_ok && !len_bad && !lines_bad)
                    state_nxt = ST_LOCKED;
            end
            ST_LOCKED: begin
                // Leaving LOCKED also stops further missing-sync reports.
                if (len_bad || lines_bad || h_miss) begin
                    err       = 1'b1;
                    state_nxt = ST_SYNCING;
                end
            end
            default: state_nxt = ST_SEARCH;
        endcase
    end

    assign locked = (state == ST_LOCKED);
    assign report = v_lead && (state != ST_SEARCH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_err   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            sync_err   <= err;
            frame_done <= report;
        end
    end

    // ---------------------------------------------------------------- pixel stats
    assign vis = (v_ctr >= V_VS_C) && (v_ctr < V_VE_C) &&
                 (h_ctr >= H_VS_C) && (h_ctr < H_VE_C);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lit_acc   <= '0;
            lit_count <= '0;
        end else if (v_lead) begin
            lit_acc <= '0;
            if (report)
                lit_count <= lit_acc;
        end else if (vis && (|rgb_s)) begin
            lit_acc <= lit_acc + 1'b1;
        end
    end

`ifdef VGA_MON_CRC_EN
    logic [CRC_W-1:0] crc_acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_acc   <= CRC_INIT;
            frame_crc <= '0;
        end else if (v_lead) begin
            crc_acc <= CRC_INIT;
            if (report)
                frame_crc <= crc_acc;
        end else if (vis) begin
            crc_acc <= crc16_step3(crc_acc, rgb_s);
        end
    end
`else
    assign frame_crc = '0;
`endif

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor on a shrunken video mode (40x20 clocks/lines)
// so that every scenario, including relock and reset recovery, runs in full frames.
module tb_vga_frame_monitor;
    localparam int HT  = 40;
    localparam int VT  = 20;
    localparam int HVS = 8;
    localparam int HV  = 24;
    localparam int VVS = 3;
    localparam int VV  = 12;
    localparam int CW  = 11;
    localparam int HSW = 4;   // hsync width, clocks
    localparam int VSW = 2;   // vsync width, lines

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          locked, sync_err, frame_done;
    logic [CW-1:0] line_len, frame_lines;
    logic [18:0]   lit_count;
    logic [15:0]   frame_crc;

    vga_frame_monitor_if vga_if ();

    vga_frame_monitor #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_VIS_START(HVS), .H_VIS(HV),
        .V_VIS_START(VVS), .V_VIS(VV), .SYNC_POL(1'b0), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .vga(vga_if),
        .locked(locked), .sync_err(sync_err), .frame_done(frame_done),
        .line_len(line_len), .frame_lines(frame_lines),
        .lit_count(lit_count), .frame_crc(frame_crc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int err_cnt = 0, err_cyc = 0, done_cnt = 0, hs_cyc = 0;
    logic hs_prev = 1'b1;
    logic [18:0] lit_cap;
    logic [15:0] crc_cap;
    logic [CW-1:0] len_cap, lines_cap;
    logic [15:0] crc_exp_cur = 16'h0, crc_exp_prev = 16'h0;

    // Lit pixels addressed in monitor counter coordinates (h_ctr, v_ctr).
    int         pix_h[$];
    int         pix_v[$];
    logic [2:0] pix_c[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] pix(input int h, input int v);
        logic [2:0] r;
        r = 3'b000;
        foreach (pix_h[i])
            if (pix_h[i] == h && pix_v[i] == v) r = pix_c[i];
        return r;
    endfunction

    // Reference CRC over the visible window in raster order, one bit at a time.
    function automatic logic [15:0] crc_model();
        logic [15:0] c;
        logic [2:0]  p;
        logic        fb;
        c = 16'hFFFF;
        for (int v = VVS; v < VVS + VV; v++)
            for (int h = HVS; h < HVS + HV; h++) begin
                p = pix(h, v);
                for (int b = 2; b >= 0; b--) begin
                    fb = c[15] ^ p[b];
                    c  = c << 1;
                    if (fb) c = c ^ 16'h1021;
                end
            end
`ifdef VGA_MON_CRC_EN
        return c;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic step(input logic [2:0] rgb, input logic hs, input logic vs);
        @(negedge clk);
        cyc++;
        if (sync_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (frame_done) begin
            done_cnt++;
            lit_cap   = lit_count;
            crc_cap   = frame_crc;
            len_cap   = line_len;
            lines_cap = frame_lines;
        end
        if (!hs && hs_prev) hs_cyc = cyc;
        hs_prev = hs;
        {vga_if.red, vga_if.green, vga_if.blue} = rgb;
        vga_if.hsync = hs;
        vga_if.vsync = vs;
    endtask

    // Pin cycle c of a line carries the pixel the monitor sees at h_ctr = c-1.
    task automatic send_lines(input int l0, input int l1, input int short_l, input int kill_l);
        for (int l = l0; l < l1; l++) begin
            int len;
            len = (l == short_l) ? HT - 1 : HT;
            for (int c = 0; c < len; c++) begin
                logic hs;
                logic vs;
                logic [2:0] rgb;
                hs  = (c < HSW && l < kill_l) ? 1'b0 : 1'b1;
                vs  = (l < VSW) ? 1'b0 : 1'b1;
                rgb = (c >= 1) ? pix(c - 1, l) : 3'b000;
                step(rgb, hs, vs);
            end
        end
    endtask

    task automatic send_frame(input int short_l, input int kill_l);
        crc_exp_prev = crc_exp_cur;
        crc_exp_cur  = crc_model();
        send_lines(0, VT, short_l, kill_l);
    endtask

    task automatic set_pix(input int h, input int v, input logic [2:0] c);
        pix_h.push_back(h);
        pix_v.push_back(v);
        pix_c.push_back(c);
    endtask

    task automatic clr_pix();
        pix_h.delete();
        pix_v.delete();
        pix_c.delete();
    endtask

    initial begin
        int done_base;
        vga_if.red = 1'b0; vga_if.green = 1'b0; vga_if.blue = 1'b0;
        vga_if.hsync = 1'b1; vga_if.vsync = 1'b1;

        // Reset state
        step(3'b000, 1'b1, 1'b1);
        step(3'b000, 1'b1, 1'b1);
        chk("rst_locked", locked, 0);
        chk("rst_err", sync_err, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_len", line_len, 0);
        chk("rst_lines", frame_lines, 0);
        chk("rst_lit", lit_count, 0);
        chk("rst_crc", frame_crc, 0);
        reset_n = 1'b1;

        // Three ideal black frames
        send_frame(-1, VT);
        chk("f1_locked", locked, 0);
        chk("f1_no_done", done_cnt, 0);
        send_frame(-1, VT);
        chk("f2_locked", locked, 1);
        send_frame(-1, VT);
        chk("f3_lines", lines_cap, VT);
        chk("f3_len", len_cap, HT);
        chk("f3_lit", lit_cap, 0);
        chk("f3_crc_black", crc_cap, crc_exp_prev);
        chk("f3_done_cnt", done_cnt, 2);
        chk("f3_no_err", err_cnt, 0);

        // One short line while locked, then relock after a full clean frame
        send_frame(5, VT);
        chk("short_err", err_cnt, 1);
        chk("short_unlock", locked, 0);
        send_frame(-1, VT);
        chk("short_still_unlocked", locked, 0);
        chk("short_lines", lines_cap, VT);
        chk("short_crc", crc_cap, crc_exp_prev);
        send_frame(-1, VT);
        chk("relock", locked, 1);

        // Lit pixel counting and window boundaries
        set_pix(HVS, VVS, 3'b100);
        send_frame(-1, VT);
        set_pix(HVS + HV - 1, VVS + VV - 1, 3'b100);
        send_frame(-1, VT);
        chk("lit_first_px", lit_cap, 1);
        chk("crc_first_px", crc_cap, crc_exp_prev);
        clr_pix();
        set_pix(HVS - 1, VVS, 3'b100);
        set_pix(HVS, VVS - 1, 3'b100);
        set_pix(HVS + HV, VVS, 3'b100);
        set_pix(HVS, VVS + VV, 3'b100);
        set_pix(HVS, VVS, 3'b010);
        send_frame(-1, VT);
        chk("lit_corners", lit_cap, 2);
        chk("crc_corners", crc_cap, crc_exp_prev);
        clr_pix();
        send_frame(-1, VT);
        chk("lit_edges", lit_cap, 1);
        chk("crc_edges", crc_cap, crc_exp_prev);
        chk("lit_locked", locked, 1);

        // hsync stuck inactive from line 3: one error when h_ctr reaches 60
        send_frame(-1, 3);
        chk("miss_err", err_cnt, 2);
        chk("miss_at", err_cyc - hs_cyc, HT + HT / 2 + 4);
        chk("miss_unlock", locked, 0);
        send_frame(-1, 3);
        chk("miss_no_repeat", err_cnt, 2);

        // Reset mid-frame while locked
        send_frame(-1, VT);
        send_frame(-1, VT);
        send_lines(0, 10, -1, VT);
        chk("pre_rst_locked", locked, 1);
        chk("pre_rst_len", line_len, HT);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_len", line_len, 0);
        chk("mid_rst_lines", frame_lines, 0);
        chk("mid_rst_done", frame_done, 0);
        step(3'b000, 1'b1, 1'b1);
        step(3'b000, 1'b1, 1'b1);
        reset_n = 1'b1;
        done_base = done_cnt;
        send_lines(10, VT, -1, VT);
        send_frame(-1, VT);
        chk("post_rst_no_done", done_cnt - done_base, 0);
        send_frame(-1, VT);
        chk("post_rst_done", done_cnt - done_base, 1);
        chk("post_rst_lines", lines_cap, VT);
        chk("post_rst_locked", locked, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
